jump_sfx_sequencer: RTL
=======================

JUMP_SFX_SEQUENCER -- requirements
Module: jump_sfx_sequencer

Interface
REQ-001 SHALL have parameter HALF_START, default 40, start square-wave half-period in samples (600 Hz at 48 kHz).
REQ-002 SHALL have parameter HALF_END, default 10, final half-period in samples; legal range 1 <= HALF_END <= HALF_START.
REQ-003 SHALL have parameter STEP_SAMPLES, default 256, samples per sweep step.
REQ-004 SHALL have parameter AMP_START, default 24'h200000, initial amplitude (positive, two's complement).
REQ-005 SHALL have parameter AMP_STEP, default 24'h010000, amplitude decrement per sweep step.
REQ-006 SHALL have port clk, input, 1, single system clock (CLOCK_50 domain); all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port trigger, input, 1, jump request, level; only its rising edge is used.
REQ-009 SHALL have port mute, input, 1, forces emitted samples to zero without stopping the sequence.
REQ-010 SHALL have port write_ready, input, 1, codec DAC FIFO can accept a sample.
REQ-011 SHALL have port write, output, 1, one-cycle sample strobe to the codec.
REQ-012 SHALL have port sample, output, 24, two's-complement sample, valid whenever write=1; drives both codec channels.
REQ-013 SHALL have port busy, output, 1, high while a sweep is playing.

Function
REQ-014 SHALL implement top FSM IDLE/PLAY and handshake FSM HS_WAIT/HS_WRITE/HS_GAP.
REQ-015 Handshake: HS_WAIT -> HS_WRITE when write_ready=1; HS_WRITE drives write=1 for exactly one cycle, then -> HS_GAP; HS_GAP -> HS_WAIT after one cycle; so write never asserts in two consecutive cycles and write_ready-to-write latency is exactly 1 cycle.
REQ-016 The handshake SHALL run in IDLE and PLAY alike; in IDLE, sample = 0 on every write.
REQ-017 Trigger edge SHALL be detected via a registered copy of trigger; an edge in any state SHALL (re)start the sweep: half=HALF_START, amp=AMP_START, step_cnt=0, phase_cnt=0, polarity=positive, state PLAY, busy=1 from the next cycle.
REQ-018 In PLAY, sample = +amp if polarity positive, else -amp (24-bit two's-complement negate); mute=1 forces 0.
REQ-019 Generator state SHALL advance only in the HS_WRITE cycle (one advance per accepted sample); the sample presented is the pre-advance value.
REQ-020 Advance: if phase_cnt >= half-1, toggle polarity and clear phase_cnt; else phase_cnt+1.
REQ-021 Advance: step_cnt+1; when step_cnt = STEP_SAMPLES-1 it wraps to 0 and, if half > HALF_END, half-1 and amp = max(amp-AMP_STEP, 0) (saturate, never wrap negative); if half = HALF_END, go IDLE, busy=0.
REQ-022 Sweep length SHALL be (HALF_START-HALF_END+1)*STEP_SAMPLES accepted samples (default 7936).
REQ-023 Trigger edge coinciding with HS_WRITE SHALL emit the old sample, then restart (restart wins over the advance and over the final-sample return to IDLE).
REQ-024 Sequence SHALL NOT advance while write_ready stays low; state holds indefinitely.

Reset
REQ-025 On reset=0, immediately: write=0, sample=0, busy=0, FSMs IDLE/HS_WAIT, all counters 0, half=HALF_START, amp=AMP_START, polarity positive, trigger history 0.
REQ-026 Reset asserted mid-sweep or mid-handshake SHALL abort with no further write pulse; after release a new trigger edge is required to play.
REQ-027 A trigger held high through reset release SHALL NOT start a sweep (history register reset to 0 only counts a 0->1 transition seen after release... history SHALL load trigger on the first post-reset clock before edges are evaluated).

Verification
REQ-028 Idle stream: write_ready=1 constant, no trigger -> write pulses every 3 cycles, sample=0, busy=0.
REQ-029 Default sweep with write_ready=1: trigger 0->1 -> first 40 samples = 24'h200000, next 40 = 24'hE00000; after 256 samples half=39, amp=24'h1F0000; busy falls after exactly 7936 writes.
REQ-030 Backpressure: write_ready low 100 cycles mid-sweep -> no write, sample index unchanged; resumes with the next sample value.
REQ-031 Retrigger at sample 5000, coincident with HS_WRITE -> that write carries old value; next write = 24'h200000, total remaining 7936 samples.
REQ-032 mute=1 during PLAY -> samples 0, busy=1, sweep still ends on schedule.
REQ-033 Reset pulse mid-sweep -> write=0, busy=0, sample=0 asynchronously; trigger held high across release -> no sweep until next 0->1 edge.

Source files
------------

// File: rtl/jump_sfx_sequencer.sv
// jump_sfx_sequencer
//   Plays a jump sound effect: a square wave whose half-period shrinks by one
//   sample every STEP_SAMPLES samples while its amplitude decays. The sweep runs
//   from HALF_START down to HALF_END. Samples are handed to the codec DAC FIFO
//   through a write_ready/write handshake. When no sweep is playing, the
//   handshake keeps running and sends zero samples.
//
// Ports
//   clk          system clock (CLOCK_50 domain), rising edge
//   reset        asynchronous active-low reset
//   trigger      jump request level; a 0->1 edge (re)starts the sweep
//   mute         forces emitted samples to zero; the sweep keeps running
//   write_ready  codec FIFO can accept a sample
//   write        one-cycle sample strobe to the codec
//   sample       24-bit two's-complement sample, valid while write=1
//   busy         high while a sweep is playing
//
// State table
//   IDLE     | no sweep; the handshake sends zero samples
//   PLAY     | sweep in progress
//   HS_WAIT  | waiting for write_ready
//   HS_WRITE | write strobe; the generator advances in this cycle
//   HS_GAP   | one dead cycle so write never pulses back-to-back
module jump_sfx_sequencer #(
  parameter int          HALF_START   = 40,
  parameter int          HALF_END     = 10,
  parameter int          STEP_SAMPLES = 256,
  parameter logic [23:0] AMP_START    = 24'h200000,
  parameter logic [23:0] AMP_STEP     = 24'h010000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic        mute,
  input  logic        write_ready,
  output logic        write,
  output logic [23:0] sample,
  output logic        busy
);

  localparam int HW = $clog2(HALF_START + 1);
  localparam int SW = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam logic [HW-1:0] HALF_START_V = HW'(HALF_START);
  localparam logic [HW-1:0] HALF_END_V   = HW'(HALF_END);
  localparam logic [SW-1:0] STEP_LAST    = SW'(STEP_SAMPLES - 1);

  typedef enum logic {IDLE, PLAY} top_state_t;
  typedef enum logic [1:0] {HS_WAIT, HS_WRITE, HS_GAP} hs_state_t;

  top_state_t      state, state_nxt;
  hs_state_t       hs_state, hs_nxt;
  logic            trig_q;
  logic            hist_valid;
  logic [HW-1:0]   half, half_nxt;
  logic [HW-1:0]   phase_cnt, phase_nxt;
  logic [SW-1:0]   step_cnt, step_nxt;
  logic [23:0]     amp, amp_nxt;
  logic            pol_neg, pol_nxt;
  logic            trig_edge;
  logic [23:0]     tone;

  // History only becomes meaningful after the first post-reset clock, so a
  // trigger held high across reset release is not seen as an edge.
  assign trig_edge = hist_valid & trigger & ~trig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hs_state   <= HS_WAIT;
      trig_q     <= 1'b0;
      hist_valid <= 1'b0;
      half       <= HALF_START_V;
      phase_cnt  <= '0;
      step_cnt   <= '0;
      amp        <= AMP_START;
      pol_neg    <= 1'b0;
    end else begin
      state      <= state_nxt;
      hs_state   <= hs_nxt;
      trig_q     <= trigger;
      hist_valid <= 1'b1;
      half       <= half_nxt;
      phase_cnt  <= phase_nxt;
      step_cnt   <= step_nxt;
      amp        <= amp_nxt;
      pol_neg    <= pol_nxt;
    end
  end

  always_comb begin
    hs_nxt = hs_state;
    case (hs_state)
      HS_WAIT:  if (write_ready) hs_nxt = HS_WRITE;
      HS_WRITE: hs_nxt = HS_GAP;
      HS_GAP:   hs_nxt = HS_WAIT;
      default:  hs_nxt = HS_WAIT;
    endcase
  end

  always_comb begin
    state_nxt = state;
    half_nxt  = half;
    phase_nxt = phase_cnt;
    step_nxt  = step_cnt;
    amp_nxt   = amp;
    pol_nxt   = pol_neg;
    if (trig_edge) begin
      // A restart takes priority over the advance and over the final sample.
      state_nxt = PLAY;
      half_nxt  = HALF_START_V;
      phase_nxt = '0;
      step_nxt  = '0;
      amp_nxt   = AMP_START;
      pol_nxt   = 1'b0;
    end else if (state == PLAY && hs_state == HS_WRITE) begin
      if (phase_cnt >= half - HW'(1)) begin
        pol_nxt   = ~pol_neg;
        phase_nxt = '0;
      end else begin
        phase_nxt = phase_cnt + HW'(1);
      end
      if (step_cnt == STEP_LAST) begin
        step_nxt = '0;
        if (half > HALF_END_V) begin
          half_nxt = half - HW'(1);
          amp_nxt  = (amp > AMP_STEP) ? (amp - AMP_STEP) : '0;
        end else begin
          state_nxt = IDLE;
        end
      end else begin
        step_nxt = step_cnt + SW'(1);
      end
    end
  end

  assign tone   = pol_neg ? (~amp + 24'd1) : amp;
  assign write  = (hs_state == HS_WRITE);
  assign busy   = (state == PLAY);
  assign sample = (write && busy && !mute) ? tone : 24'd0;

endmodule
